// File: rtl/router_pkg.sv
// Shared constants for the router output-port FIFO slice.
// Header layout: [7:2] payload length, [1:0] destination port.
package router_pkg;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int LEN_MSB    = 7;
  localparam int LEN_LSB    = 2;
  localparam int ADDR_MSB   = 1;
  localparam int ADDR_LSB   = 0;
  localparam int COUNT_W    = 7;
  localparam int LEN_W      = LEN_MSB - LEN_LSB + 1;
endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/pop/status bundle between the register stage, the port
// reader and one output-port FIFO.
interface router_pkt_fifo_if
  import router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             full;
  logic             empty;
  logic             pkt_busy;
  logic             framing_err;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, data_valid, full, empty,
    input  pkt_busy, framing_err
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, data_valid, full, empty,
    output pkt_busy, framing_err
  );
endinterface

// File: rtl/router_pkt_counter.sv
// Packet byte counter: loads from each popped header and counts
// payload plus parity down; flags orphan or truncating pops.
module router_pkt_counter
  import router_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             pop,
  input  logic             tag,
  input  logic [LEN_W-1:0] len,
  output logic             pkt_busy,
  output logic             framing_err
);
  logic [COUNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= '0;
      framing_err <= 1'b0;
    end else if (soft_reset) begin
      count       <= '0;
      framing_err <= 1'b0;
    end else if (pop) begin
      if (tag) begin
        // +1 accounts for the trailing parity byte
        count <= COUNT_W'(len) + COUNT_W'(1);
        if (count != '0)
          framing_err <= 1'b1;
      end else if (count != '0) begin
        count <= count - COUNT_W'(1);
      end else begin
        framing_err <= 1'b1;
      end
    end
  end

  assign pkt_busy = (count != '0);
endmodule

// File: rtl/router_pkt_fifo.sv
// Output-port packet FIFO: tagged storage, wrap-bit pointers and a
// registered pop port feeding the per-packet byte counter.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        soft_reset,
  router_pkt_fifo_if.slave bus
);
  localparam int PTR_W = ADDR_W + 1;

  logic [WIDTH:0]     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               lfd_d;
  logic [WIDTH-1:0]   data_out;
  logic               data_valid;
  logic               full;
  logic               empty;
  logic               do_wr;
  logic               do_rd;
  logic [WIDTH:0]     rd_word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign do_wr   = bus.write_enb && !full && !soft_reset;
  assign do_rd   = bus.read_enb && !empty && !soft_reset;
  assign rd_word = mem[rd_ptr[ADDR_W-1:0]];

  // storage is deliberately left out of both resets
  always_ff @(posedge clock) begin
    if (do_wr)
      mem[wr_ptr[ADDR_W-1:0]] <= {lfd_d, bus.data_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lfd_d      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lfd_d      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      lfd_d      <= bus.lfd_state;
      data_valid <= do_rd;
      if (do_wr)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        data_out <= rd_word[WIDTH-1:0];
      end
    end
  end

  router_pkt_counter u_cnt (
    .clock       (clock),
    .reset       (reset),
    .soft_reset  (soft_reset),
    .pop         (do_rd),
    .tag         (rd_word[WIDTH]),
    .len         (rd_word[LEN_MSB:LEN_LSB]),
    .pkt_busy    (bus.pkt_busy),
    .framing_err (bus.framing_err)
  );

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.full       = full;
  assign bus.empty      = empty;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo against a queue-based
// model of the packet FIFO and its byte counter.
module tb_router_pkt_fifo;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic soft_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   running = 0;

  router_pkt_fifo_if bus ();

  router_pkt_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  logic [8:0] mq[$];
  logic [7:0] exp_q[$];
  bit         m_lfd_d;
  int         m_count;
  bit         m_ferr;
  bit         m_dv;
  logic [7:0] m_dout;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    exp_q.delete();
    m_lfd_d = 0;
    m_count = 0;
    m_ferr  = 0;
    m_dv    = 0;
    m_dout  = 8'h00;
  endfunction

  function automatic void model_edge(bit we, bit re, bit lfd,
                                     bit srst, logic [7:0] din);
    bit         is_full;
    bit         is_empty;
    logic [8:0] w;
    if (srst) begin
      mq.delete();
      m_lfd_d = 0;
      m_count = 0;
      m_ferr  = 0;
      m_dv    = 0;
      m_dout  = 8'h00;
      return;
    end
    is_full  = (mq.size() == 16);
    is_empty = (mq.size() == 0);
    m_dv = 0;
    if (re && !is_empty) begin
      w = mq.pop_front();
      m_dout = w[7:0];
      m_dv = 1;
      exp_q.push_back(w[7:0]);
      if (w[8]) begin
        if (m_count != 0) m_ferr = 1;
        m_count = int'(w[7:2]) + 1;
      end else if (m_count == 0) begin
        m_ferr = 1;
      end else begin
        m_count--;
      end
    end
    if (we && !is_full)
      mq.push_back({m_lfd_d, din});
    m_lfd_d = lfd;
  endfunction

  task automatic step(bit we, bit re, bit lfd, bit srst,
                      logic [7:0] din);
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    soft_reset    = srst;
    @(posedge clock);
    model_edge(we, re, lfd, srst, din);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
  endtask

  task automatic do_reset();
    bus.write_enb = 0;
    bus.read_enb  = 0;
    bus.lfd_state = 0;
    bus.data_in   = 8'h00;
    soft_reset    = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_dout", int'(bus.data_out), 0);
    chk("rst_dvalid", int'(bus.data_valid), 0);
    chk("rst_busy", int'(bus.pkt_busy), 0);
    chk("rst_ferr", int'(bus.framing_err), 0);
    model_reset();
    @(negedge clock);
    #2;
    reset = 1'b0;
    running = 1;
    step(0, 0, 0, 0, 8'h00);
  endtask

  always @(negedge clock) begin
    if (running && !reset) begin
      chk("data_valid", int'(bus.data_valid), int'(m_dv));
      if (bus.data_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: unexpected pop %0h at %0t",
                   bus.data_out, $time);
        end else begin
          chk("data_out", int'(bus.data_out),
              int'(exp_q.pop_front()));
        end
      end else begin
        chk("data_out_hold", int'(bus.data_out), int'(m_dout));
      end
      chk("full", int'(bus.full), int'(mq.size() == 16));
      chk("empty", int'(bus.empty), int'(mq.size() == 0));
      chk("pkt_busy", int'(bus.pkt_busy), int'(m_count != 0));
      chk("framing_err", int'(bus.framing_err), int'(m_ferr));
      chk("count", int'(dut.u_cnt.count), m_count);
    end
  end

  task automatic send_pkt(logic [7:0] hdr, int n);
    logic [7:0] par;
    logic [7:0] b;
    par = hdr;
    step(0, 0, 1, 0, 8'h00);
    step(1, 0, 0, 0, hdr);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      par ^= b;
      step(1, 0, 0, 0, b);
    end
    step(1, 0, 0, 0, par);
  endtask

  initial begin
    bus.write_enb = 0;
    bus.read_enb  = 0;
    bus.lfd_state = 0;
    bus.data_in   = 8'h00;
    @(posedge clock);
    #1;
    do_reset();

    // single packet, header 0x16: len 5, port 2
    send_pkt(8'h16, 5);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 8'h00);
    idle(2);

    // full boundary, dropped 0xAA
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 16; i++)
      step(1, 0, 0, 0, 8'($urandom_range(0, 8'hA9)));
    step(1, 0, 0, 0, 8'hAA);
    step(1, 1, 0, 0, 8'hAA);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h3C);
    step(0, 1, 0, 0, 8'h00);
    idle(1);

    // soft reset mid-packet with a concurrent write
    step(0, 0, 0, 1, 8'h00);
    send_pkt(8'h16, 5);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 1, 8'h77);
    idle(2);

    // orphan word sets sticky framing error
    step(1, 0, 0, 0, 8'h55);
    step(0, 1, 0, 0, 8'h00);
    send_pkt(8'h08, 2);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
    idle(1);
    step(0, 0, 0, 1, 8'h00);
    idle(1);

    // zero-length header and truncated packet
    send_pkt(8'h01, 0);
    send_pkt(8'h0C, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 8'h00);

    // async reset in the middle of a packet
    send_pkt(8'h1B, 4);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
           8'($urandom));
    end
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 8'h00);
    idle(1);

    running = 0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d pops not seen",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "timeout");
  end
endmodule
